bc_input_conditioner: RTL

Upstream stage of the Bulls and Cows game core. Converts the raw board inputs (4-bit code switches, enter push-button) into clean, clock-synchronous events. It synchronizes both inputs, debounces the button, and captures the switch value on each accepted press. It emits exactly one single-cycle event per physical press: either a valid digit strobe or a range-error strobe. Its outputs drive the game core's `code` and `enter_button` inputs directly.

---
 rtl/bc_pkg.sv | 16 +
 rtl/bc_input_conditioner_if.sv | 22 ++
 rtl/bc_sync2ff.sv | 28 ++
 rtl/bc_input_conditioner.sv | 119 +++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared types and constants for the Bulls and Cows input path and game core.
package bc_pkg;

  localparam int BC_CODE_W    = 4;
  localparam int BC_MAX_DIGIT = 9;

  typedef logic [BC_CODE_W-1:0] bc_code_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } bc_in_state_t;

endpackage

// File: rtl/bc_input_conditioner_if.sv
// Board-side raw inputs and conditioned event outputs of the input conditioner.
interface bc_input_conditioner_if;
  import bc_pkg::*;

  bc_code_t code_raw;
  logic     enter_raw;
  bc_code_t code;
  logic     enter_pulse;
  logic     code_err;
  logic     busy;

  modport master (
    output code_raw, enter_raw,
    input  code, enter_pulse, code_err, busy
  );

  modport slave (
    input  code_raw, enter_raw,
    output code, enter_pulse, code_err, busy
  );

endinterface

// File: rtl/bc_sync2ff.sv
// Per-bit two-flop synchronizer for signals arriving asynchronously to clock.
module bc_sync2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
      end else begin
        meta_q <= d_i[gi];
        sync_q <= meta_q;
      end
    end

    assign q_o[gi] = sync_q;
  end

endmodule

// File: rtl/bc_input_conditioner.sv
// Synchronizes and debounces the enter button, capturing the switch code on each
// accepted press as either a valid-digit strobe or a range-error strobe.
module bc_input_conditioner
  import bc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MAX_DIGIT       = BC_MAX_DIGIT
) (
  input  logic                   clock,
  input  logic                   reset,
  bc_input_conditioner_if.slave  bus
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam bc_code_t          MAX_CODE = BC_CODE_W'(MAX_DIGIT);

  logic         enter_s;
  bc_code_t     code_s;

  bc_in_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  bc_code_t         code_q, code_d;
  logic             pulse_q, pulse_d;
  logic             err_q, err_d;

  bc_sync2ff #(.WIDTH(1)) u_sync_enter (
    .clock (clock),
    .reset (reset),
    .d_i   (bus.enter_raw),
    .q_o   (enter_s)
  );

  bc_sync2ff #(.WIDTH(BC_CODE_W)) u_sync_code (
    .clock (clock),
    .reset (reset),
    .d_i   (bus.code_raw),
    .q_o   (code_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  // The counter holds its value outside the wait states; it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enter_s) begin
          cnt_d   = CNT_LOAD;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!enter_s) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          accept  = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (!enter_s) begin
          cnt_d   = CNT_LOAD;
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (enter_s) begin
          state_d = HELD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An out-of-range press still consumes the press but leaves the digit untouched.
  always_comb begin
    code_d  = code_q;
    pulse_d = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      if (code_s <= MAX_CODE) begin
        code_d  = code_s;
        pulse_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign bus.code        = code_q;
  assign bus.enter_pulse = pulse_q;
  assign bus.code_err    = err_q;
  assign bus.busy        = (state_q != IDLE);

endmodule
